// File: rtl/mips_boot_mem_pkg.sv
// Shared definitions for the boot-loading unified memory: word width,
// default depth and the loader FSM state encoding.
package mips_boot_mem_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned DEFAULT_DEPTH = 1024;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mips_boot_mem_if.sv
// Bus bundle for mips_boot_mem: core access port, boot stream port and status.
// The align_err status line exists only when MIPS_MEM_ALIGN_CHECK_EN is defined.
interface mips_boot_mem_if #(
    parameter int unsigned DEPTH = mips_boot_mem_pkg::DEFAULT_DEPTH
);
    import mips_boot_mem_pkg::*;

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    // Core side
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       adr_to_write;
    logic [WORD_W-1:0] data_to_mem;
    logic [WORD_W-1:0] mem;

    // Boot stream side
    logic              boot_valid;
    logic              boot_ready;
    logic [WORD_W-1:0] boot_data;
    logic              boot_last;

    // Status
    logic              cpu_run;
    logic [ADDR_W:0]   load_count;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
    logic              align_err;
`endif

    // Driver of strobes and boot words (core + boot source)
    modport master (
        output mem_read, mem_write, adr_to_write, data_to_mem,
        output boot_valid, boot_data, boot_last,
        input  mem, boot_ready, cpu_run, load_count
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        , input align_err
`endif
    );

    // The memory itself
    modport slave (
        input  mem_read, mem_write, adr_to_write, data_to_mem,
        input  boot_valid, boot_data, boot_last,
        output mem, boot_ready, cpu_run, load_count
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        , output align_err
`endif
    );

endinterface

// File: rtl/mips_sp_ram.sv
// Single-port synchronous RAM with a registered read port.
// A read and a write to the same word on one edge returns the old contents.
module mips_sp_ram
    import mips_boot_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] ram [DEPTH];

    // Storage array; deliberately not reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end

    // Registered read; holds its value when re is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= ram[addr];
        end
    end

endmodule

// File: rtl/mips_boot_mem.sv
// Unified instruction/data memory for the multi-cycle MIPS core.
// After reset a loader streams boot words into RAM while the core is held,
// then releases it via cpu_run and serves core reads/writes.
// Optional feature: MIPS_MEM_ALIGN_CHECK_EN adds a sticky align_err flag and
// suppresses misaligned writes.
module mips_boot_mem
    import mips_boot_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input logic            clk,
    input logic            rst,
    mips_boot_mem_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(DEPTH - 1);

    state_e            state;
    logic              boot_ready_q;
    logic              cpu_run_q;
    logic [ADDR_W:0]   load_count_q;

    logic              boot_xfer;
    logic [ADDR_W-1:0] core_idx;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_re;

    // Address bits outside the word index are intentionally dropped.
    logic unused_adr;
    assign unused_adr = ^{bus.adr_to_write[31:ADDR_W+2], bus.adr_to_write[1:0]};

`ifdef MIPS_MEM_ALIGN_CHECK_EN
    logic misaligned;
    logic align_err_q;
    assign misaligned = bus.adr_to_write[1:0] != 2'b00;
`endif

    // RAM port mux: loader owns the port in BOOT, the core owns it in RUN.
    always_comb begin
        boot_xfer = (state == ST_BOOT) && bus.boot_valid && boot_ready_q;
        core_idx  = bus.adr_to_write[ADDR_W+1:2];
        ram_addr  = core_idx;
        ram_wdata = bus.data_to_mem;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        if (state == ST_BOOT) begin
            ram_addr  = load_count_q[ADDR_W-1:0];
            ram_wdata = bus.boot_data;
            ram_we    = boot_xfer;
        end else begin
            ram_re = bus.mem_read;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
            ram_we = bus.mem_write && !misaligned;
`else
            ram_we = bus.mem_write;
`endif
        end
    end

    // Loader FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_BOOT;
            boot_ready_q <= 1'b1;
            cpu_run_q    <= 1'b0;
            load_count_q <= '0;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
            align_err_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_BOOT: begin
                    if (boot_xfer) begin
                        load_count_q <= load_count_q + 1'b1;
                        if (bus.boot_last || (load_count_q == LastIdx)) begin
                            state        <= ST_RUN;
                            boot_ready_q <= 1'b0;
                            cpu_run_q    <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
`ifdef MIPS_MEM_ALIGN_CHECK_EN
                    if ((bus.mem_read || bus.mem_write) && misaligned) begin
                        align_err_q <= 1'b1;
                    end
`endif
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

    mips_sp_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (bus.mem)
    );

    assign bus.boot_ready = boot_ready_q;
    assign bus.cpu_run    = cpu_run_q;
    assign bus.load_count = load_count_q;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
    assign bus.align_err  = align_err_q;
`endif

endmodule

// File: tb/tb_mips_boot_mem.sv
// Directed bench for mips_boot_mem with a read scoreboard and a RAM model.
module tb_mips_boot_mem;

    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mips_boot_mem_if #(.DEPTH(DEPTH)) bus ();

    mips_boot_mem #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic boot_word(input logic [31:0] d, input logic last);
        bus.boot_valid = 1'b1;
        bus.boot_data  = d;
        bus.boot_last  = last;
        step();
        bus.boot_valid = 1'b0;
        bus.boot_last  = 1'b0;
    endtask

    // Read with optional same-cycle write; expected data enters the scoreboard
    // when the strobe is driven and is checked one edge later.
    task automatic access(input string tag, input logic [31:0] adr, input logic rd,
                          input logic wr, input logic [31:0] wd, input logic wr_lands);
        int unsigned idx;
        idx = adr[11:2];
        bus.adr_to_write = adr;
        bus.mem_read     = rd;
        bus.mem_write    = wr;
        bus.data_to_mem  = wd;
        if (rd) exp_q.push_back(model[idx]);
        if (wr && wr_lands) model[idx] = wd;
        step();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        if (rd) begin
            if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            else chk(tag, bus.mem, exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_cpu_run", {31'd0, bus.cpu_run}, 32'd0);
        chk("rst_mem", bus.mem, 32'd0);
        chk("rst_boot_ready", {31'd0, bus.boot_ready}, 32'd1);
        chk("rst_load_count", {21'd0, bus.load_count}, 32'd0);
        step();
        rst = 1'b1;
    endtask

    initial begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.adr_to_write = '0; bus.data_to_mem = '0;
        bus.boot_valid = 1'b0; bus.boot_data = '0; bus.boot_last = 1'b0;
        #12;
        do_reset();
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        chk("rst_align_err", {31'd0, bus.align_err}, 32'd0);
`endif

        // Boot 4 words; core read strobe during boot must be ignored.
        bus.mem_read = 1'b1;
        boot_word(32'h11, 1'b0); model[0] = 32'h11;
        bus.mem_read = 1'b0;
        chk("boot_mem_hold", bus.mem, 32'd0);
        boot_word(32'h22, 1'b0); model[1] = 32'h22;
        boot_word(32'h33, 1'b0); model[2] = 32'h33;
        chk("boot3_cpu_run", {31'd0, bus.cpu_run}, 32'd0);
        chk("boot3_count", {21'd0, bus.load_count}, 32'd3);
        boot_word(32'h44, 1'b1); model[3] = 32'h44;
        chk("boot4_count", {21'd0, bus.load_count}, 32'd4);
        chk("boot4_cpu_run", {31'd0, bus.cpu_run}, 32'd1);
        chk("boot4_ready", {31'd0, bus.boot_ready}, 32'd0);

        // Boot port ignored in RUN.
        boot_word(32'h99, 1'b0);
        chk("run_boot_ignored_count", {21'd0, bus.load_count}, 32'd4);

        // Read latency and hold.
        access("rd_8", 32'h8, 1'b1, 1'b0, '0, 1'b0);
        step(); step();
        chk("rd_hold", bus.mem, 32'h33);

        // Read-before-write on the same word.
        access("rbw_old", 32'h4, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
        access("rbw_new", 32'h4, 1'b1, 1'b0, '0, 1'b0);
        access("rd_0", 32'h0, 1'b1, 1'b0, '0, 1'b0);
        access("rd_high_wrap", 32'hFFFF_F00C, 1'b1, 1'b0, '0, 1'b0);

        // Misaligned write to 0x6 (word 1).
`ifdef MIPS_MEM_ALIGN_CHECK_EN
        access("wr_mis", 32'h6, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        chk("align_err_set", {31'd0, bus.align_err}, 32'd1);
        access("rd_after_mis", 32'h4, 1'b1, 1'b0, '0, 1'b0);
        chk("align_err_sticky", {31'd0, bus.align_err}, 32'd1);
`else
        access("wr_mis", 32'h6, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
        access("rd_after_mis", 32'h4, 1'b1, 1'b0, '0, 1'b0);
`endif
        access("rd_mis_9", 32'h9, 1'b1, 1'b0, '0, 1'b0);

        // Reset during boot, then reboot two words.
        do_reset();
        boot_word(32'h1, 1'b0);
        boot_word(32'h2, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("midboot_cpu_run", {31'd0, bus.cpu_run}, 32'd0);
        chk("midboot_count", {21'd0, bus.load_count}, 32'd0);
        chk("midboot_mem", bus.mem, 32'd0);
        step();
        rst = 1'b1;
        boot_word(32'hA, 1'b0); model[0] = 32'hA;
        boot_word(32'hB, 1'b1); model[1] = 32'hB;
        chk("reboot_count", {21'd0, bus.load_count}, 32'd2);
        chk("reboot_cpu_run", {31'd0, bus.cpu_run}, 32'd1);
        access("reboot_rd0", 32'h0, 1'b1, 1'b0, '0, 1'b0);
        access("reboot_rd1", 32'h4, 1'b1, 1'b0, '0, 1'b0);
        access("reboot_rd2_kept", 32'h8, 1'b1, 1'b0, '0, 1'b0);

        // Full-depth boot without boot_last.
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) begin
            boot_word(32'h5A5A_0000 ^ i, 1'b0);
            model[i] = 32'h5A5A_0000 ^ i;
        end
        chk("full_pre_cpu_run", {31'd0, bus.cpu_run}, 32'd0);
        chk("full_pre_count", {21'd0, bus.load_count}, DEPTH - 1);
        boot_word(32'hC0DE_0000, 1'b0); model[DEPTH-1] = 32'hC0DE_0000;
        chk("full_cpu_run", {31'd0, bus.cpu_run}, 32'd1);
        chk("full_count", {21'd0, bus.load_count}, DEPTH);
        boot_word(32'hFFFF_FFFF, 1'b0);
        chk("full_count_sat", {21'd0, bus.load_count}, DEPTH);
        access("full_wrap_rd", 4 * DEPTH, 1'b1, 1'b0, '0, 1'b0);
        access("full_last_rd", 32'hFFFF_FFFC, 1'b1, 1'b0, '0, 1'b0);
        access("full_mid_rd", 32'h200, 1'b1, 1'b0, '0, 1'b0);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
